ltc2308_responder: RTL

- Synthesizable emulator of the LTC2308 serial interface, i.e. the ADC-side responder to the on-board LTC2308 controller.
- Placed on GPIO pins, it lets the FPGA-side ADC controller and HPS software be looped back and regression-tested without the real converter.
- Returns 12-bit samples from a parallel channel bus on SDO, selected and formatted by the 6-bit config word received on SDI in the previous frame.
- All protocol inputs are oversampled on one system clock.

---
 rtl/ltc2308_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/ltc2308_responder.sv
// ltc2308_responder: LTC2308 serial-interface emulator returning samples from a parallel channel bus.
module ltc2308_responder #(
  parameter int DATA_W      = 12,
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adc_convst,
  input  logic                  adc_sck,
  input  logic                  adc_sdi,
  output logic                  adc_sdo,
  output logic                  adc_sdo_oe,
  input  logic [8*DATA_W-1:0]   ch_data,
  output logic [5:0]            cfg_word,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  overrun
);
  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, WAIT = 2'd2, SHIFT = 2'd3;
  localparam int TXW = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  logic [SYNC_STAGES-1:0] cs_q, sck_q, sdi_q;
  logic                   cs_d, sck_d;
  logic                   cs_s, cs_rise, sck_rise, sck_fall, frame_end;
  logic [1:0]             state;
  logic [15:0]            cnt;
  logic [DATA_W-1:0]      shift_reg, raw, sample;
  logic [5:0]             cfg_shift;
  logic [4:0]             cfg_sel;
  logic [2:0]             rx_cnt, ch;
  logic [TXW-1:0]         tx_cnt;
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_d;
  assign sck_rise  = sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall  = ~sck_q[SYNC_STAGES-1] & sck_d;
  assign frame_end = (state == SHIFT) && cs_rise;
  // A config completed in this frame already selects the sample latched on the same edge.
  always_comb begin
    cfg_sel = (frame_end && rx_cnt == 3'd6) ? cfg_shift[5:1] : cfg_word[5:1];
    ch      = {cfg_sel[2], cfg_sel[1], cfg_sel[3]};
    raw     = cfg_sel[4] ? ch_data[ch*DATA_W +: DATA_W] : MID;
    sample  = cfg_sel[0] ? raw : raw ^ MID;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q  <= '0;
      sck_q <= '0;
      sdi_q <= '0;
      cs_d  <= 1'b0;
      sck_d <= 1'b0;
    end else begin
      cs_q  <= {cs_q[SYNC_STAGES-2:0], adc_convst};
      sck_q <= {sck_q[SYNC_STAGES-2:0], adc_sck};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], adc_sdi};
      cs_d  <= cs_q[SYNC_STAGES-1];
      sck_d <= sck_q[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      adc_sdo     <= 1'b0;
      adc_sdo_oe  <= 1'b0;
      cfg_word    <= 6'h22;
      busy        <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      cnt         <= '0;
      shift_reg   <= '0;
      cfg_shift   <= '0;
      rx_cnt      <= '0;
      tx_cnt      <= '0;
    end else begin
      if ((state == IDLE || state == SHIFT) && cs_rise) begin
        state      <= CONV;
        busy       <= 1'b1;
        cnt        <= 16'(CONV_CYCLES - 1);
        shift_reg  <= sample;
        cfg_shift  <= '0;
        rx_cnt     <= '0;
        tx_cnt     <= '0;
        adc_sdo    <= 1'b0;
        adc_sdo_oe <= 1'b0;
      end
      if (frame_end) begin
        frame_count <= frame_count + 16'd1;
        cfg_word    <= (rx_cnt == 3'd6) ? cfg_shift : cfg_word;
        overrun     <= overrun | (rx_cnt != 3'd6);
      end
      if (state == CONV) begin
        overrun <= overrun | cs_rise;
        cnt     <= cnt - 16'd1;
        if (cnt == 16'd0) begin
          state <= WAIT;
          busy  <= 1'b0;
        end
      end
      if (state == WAIT && !cs_s) begin
        state      <= SHIFT;
        adc_sdo_oe <= 1'b1;
        adc_sdo    <= shift_reg[DATA_W-1];
      end
      if (state == SHIFT && !cs_rise) begin
        if (sck_rise && rx_cnt < 3'd6) begin
          cfg_shift <= {cfg_shift[4:0], sdi_q[SYNC_STAGES-1]};
          rx_cnt    <= rx_cnt + 3'd1;
        end
        if (sck_fall) begin
          shift_reg <= shift_reg << 1;
          adc_sdo   <= (tx_cnt < TXW'(DATA_W - 1)) & shift_reg[DATA_W-2];
          tx_cnt    <= tx_cnt + TXW'(tx_cnt != TXW'(DATA_W));
        end
      end
    end
  end
endmodule
